lsu_mem_ctrl: RTL and testbench
===============================

// Module: lsu_mem_ctrl
// PURPOSE
//  Load/store sequencer between the execute stage and the data-memory port.
//  Accepts one access per handshake, using the mem_op encoding (000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu).
//  Checks alignment and aligns store data and byte masks onto a word-addressed memory bus.
//  Waits for grant and read data, then extracts and extends load data and returns a single response.
// PARAMETERS
//  TIMEOUT   255  max cycles spent in REQ+WAIT before aborting with timeout error (1..65535)
// PORTS
//  clk         in   1   clock, rising edge
//  rst_n       in   1   asynchronous reset, active low
//  in_valid    in   1   request valid
//  in_ready    out  1   request accepted when in_valid&&in_ready
//  in_we       in   1   1=store, 0=load
//  in_op       in   3   mem_op encoding above
//  in_addr     in   32  byte address
//  in_wdata    in   32  store data (low bytes significant)
//  out_valid   out  1   response valid
//  out_ready   in   1   response consumed when out_valid&&out_ready
//  out_rdata   out  32  extended load data (0 for stores and errors)
//  out_err     out  2   00 ok, 01 misaligned, 10 illegal op, 11 timeout
//  mem_req     out  1   memory request
//  mem_gnt     in   1   memory accepts request this cycle
//  mem_we      out  1   write strobe, qualified by mem_req
//  mem_addr    out  32  word address {in_addr[31:2],2'b00}
//  mem_wdata   out  32  lane-aligned store data
//  mem_wmask   out  4   byte-lane mask (0000 for loads)
//  mem_rvalid  in   1   read data valid
//  mem_rdata   in   32  raw read word
// BEHAVIOUR
//  Reset values: state=IDLE, in_ready=1, out_valid=0, out_rdata=0, out_err=00, mem_req=0,
//  mem_we=0, mem_addr=0, mem_wdata=0, mem_wmask=0, timeout counter=0.
//  Reset mid-operation aborts any access immediately; mem_req drops asynchronously and no response is issued.
//  FSM IDLE -> REQ | RESP; REQ -> WAIT | RESP; WAIT -> RESP; RESP -> IDLE.
//  IDLE
//   - in_ready=1. On handshake, latch we/op/addr/wdata.
//   - op in {011,110,111} -> RESP, err=10.
//   - Misaligned access (half with addr[0]=1; word with addr[1:0]!=0) -> RESP, err=01. No mem_req is raised.
//   - Illegal-op takes priority over misaligned.
//   - Otherwise -> REQ.
//  REQ
//   - mem_req=1; mem_* outputs are registered and held stable until grant.
//   - On mem_gnt: store -> RESP, err=00; load -> WAIT.
//  WAIT
//   - mem_req=0. On mem_rvalid, sh = mem_rdata >> (8*addr[1:0]).
//   - Data: lb {{24{sh[7]}},sh[7:0]}; lbu {24'b0,sh[7:0]}; lh {{16{sh[15]}},sh[15:0]}; lhu {16'b0,sh[15:0]}; lw sh.
//   - -> RESP, err=00.
//  RESP
//   - out_valid=1; out_rdata and out_err are held stable until out_ready, then -> IDLE.
//  Timeout counter
//   - Cleared on acceptance; increments each cycle in REQ/WAIT.
//   - On reaching TIMEOUT: mem_req drops, -> RESP, err=11.
//   - Timeout takes priority over a same-cycle gnt/rvalid.
//  in_ready=0 outside IDLE; at most one access is outstanding.
//  mem_rvalid is ignored outside WAIT; mem_gnt is ignored outside REQ.
//  Store alignment
//   - byte: wdata={4{d[7:0]}}, wmask=0001<<addr[1:0].
//   - half: wdata={2{d[15:0]}}, wmask=0011<<addr[1:0].
//   - word: wdata=d, wmask=1111.
//  Minimum latency (gnt in first REQ cycle, rvalid one cycle later):
//   - load: accept at cycle 0, out_valid at cycle 3.
//   - store: accept at cycle 0, out_valid at cycle 2.
//   - error: accept at cycle 0, out_valid at cycle 1.
// TESTING
//  lb addr=0x80000003, mem_rdata=0x80FF0000, gnt immediate, rvalid +1 -> out_rdata=0xFFFFFF80, err=00, out_valid at cycle 3.
//  lhu addr=0x80000002, mem_rdata=0xBEEF1234 -> out_rdata=0x0000BEEF.
//  sb addr=0x80000001, in_wdata=0x000000AB -> mem_wdata=0xABABABAB, wmask=0010, mem_we=1, mem_addr=0x80000000.
//  lw addr=0x80000002 -> err=01 next cycle, mem_req never asserted; op=011 -> err=10.
//  gnt withheld 4 cycles, out_ready low 3 cycles -> mem_* and out_* stable throughout, single response.
//  TIMEOUT=8, no rvalid -> err=11 after 8 cycles; rst_n pulsed in WAIT -> mem_req=0, out_valid=0, in_ready=1.

Source files
------------

// File: rtl/lsu_mem_ctrl.sv
// Load/store sequencer between the execute stage and a word-addressed data
// memory port. One access is in flight at a time: it is checked for legality
// and alignment, presented on the memory bus until granted, and loads wait
// for read data before one response goes back to the execute stage.
module lsu_mem_ctrl #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_we,
  input  logic [2:0]  in_op,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_wdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_rdata,
  output logic [1:0]  out_err,
  output logic        mem_req,
  input  logic        mem_gnt,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

  localparam logic [1:0]  ERR_OK       = 2'b00;
  localparam logic [1:0]  ERR_MISALIGN = 2'b01;
  localparam logic [1:0]  ERR_ILLEGAL  = 2'b10;
  localparam logic [1:0]  ERR_TIMEOUT  = 2'b11;
  // Counter value seen during the last cycle an access may spend in REQ/WAIT.
  localparam logic [15:0] TMO_LAST     = 16'(TIMEOUT - 1);

  state_t      state, state_nxt;
  logic [15:0] tmo_cnt;
  logic        op_we_q;
  logic [2:0]  op_q;
  logic [1:0]  off_q;
  logic        accept, illegal_op, misaligned, tmo_hit;
  logic [31:0] st_wdata, ld_shifted, ld_data;
  logic [3:0]  st_wmask;

  assign accept     = in_valid && in_ready;
  assign illegal_op = (in_op == 3'b011) || (in_op == 3'b110) || (in_op == 3'b111);
  // Only 010 reaches the word check: 110 is already rejected as illegal.
  assign misaligned = ((in_op[1:0] == 2'b01) && in_addr[0]) ||
                      ((in_op[1:0] == 2'b10) && (in_addr[1:0] != 2'b00));
  assign tmo_hit    = ((state == S_REQ) || (state == S_WAIT)) && (tmo_cnt == TMO_LAST);

  // State register.
  // NOTE: every register in an always_ff uses non-blocking assignment so all
  // flops update from pre-edge values; blocking here creates order-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; timeout wins over a same-cycle grant or read data.
  // NOTE: the default assignment on entry keeps every path assigned, so no latch is inferred.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: if (accept) state_nxt = (illegal_op || misaligned) ? S_RESP : S_REQ;
      S_REQ: begin
        if (tmo_hit)      state_nxt = S_RESP;
        else if (mem_gnt) state_nxt = op_we_q ? S_RESP : S_WAIT;
      end
      S_WAIT: if (tmo_hit || mem_rvalid) state_nxt = S_RESP;
      S_RESP: if (out_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Handshake outputs decoded from the current state.
  always_comb begin
    in_ready  = (state == S_IDLE);
    out_valid = (state == S_RESP);
  end

  // Store data replicated across lanes and the byte mask of the addressed lanes.
  always_comb begin
    st_wdata = in_wdata;
    st_wmask = 4'b1111;
    case (in_op[1:0])
      2'b00: begin
        st_wdata = {4{in_wdata[7:0]}};
        st_wmask = 4'b0001 << in_addr[1:0];
      end
      2'b01: begin
        st_wdata = {2{in_wdata[15:0]}};
        st_wmask = 4'b0011 << in_addr[1:0];
      end
      default: ;
    endcase
  end

  // Load data shifted down to the addressed lane, then sign/zero extended.
  always_comb begin
    ld_shifted = mem_rdata >> {off_q, 3'b000};
    case (op_q)
      3'b000:  ld_data = {{24{ld_shifted[7]}}, ld_shifted[7:0]};
      3'b001:  ld_data = {{16{ld_shifted[15]}}, ld_shifted[15:0]};
      3'b100:  ld_data = {24'b0, ld_shifted[7:0]};
      3'b101:  ld_data = {16'b0, ld_shifted[15:0]};
      default: ld_data = ld_shifted;
    endcase
  end

  // Access context, memory bus registers, timeout counter and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_we_q   <= 1'b0;
      op_q      <= 3'b000;
      off_q     <= 2'b00;
      tmo_cnt   <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wmask <= 4'b0000;
      out_rdata <= '0;
      out_err   <= ERR_OK;
    end else begin
      case (state)
        S_IDLE: if (accept) begin
          op_we_q   <= in_we;
          op_q      <= in_op;
          off_q     <= in_addr[1:0];
          tmo_cnt   <= '0;
          out_rdata <= '0;
          if (illegal_op)      out_err <= ERR_ILLEGAL;
          else if (misaligned) out_err <= ERR_MISALIGN;
          else begin
            out_err   <= ERR_OK;
            mem_req   <= 1'b1;
            mem_we    <= in_we;
            mem_addr  <= {in_addr[31:2], 2'b00};
            mem_wdata <= st_wdata;
            mem_wmask <= in_we ? st_wmask : 4'b0000;
          end
        end
        S_REQ: begin
          tmo_cnt <= tmo_cnt + 16'd1;
          if (tmo_hit || mem_gnt) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
          end
          if (tmo_hit) out_err <= ERR_TIMEOUT;
        end
        S_WAIT: begin
          tmo_cnt <= tmo_cnt + 16'd1;
          if (tmo_hit)         out_err   <= ERR_TIMEOUT;
          else if (mem_rvalid) out_rdata <= ld_data;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Bench for lsu_mem_ctrl: directed cases with literal expectations followed by
// random transactions. A transaction-level model predicts the response, the
// bus request contents and the cycle-by-cycle handshake timing of each access.
`timescale 1ns/1ps
module tb_lsu_mem_ctrl;

  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid, in_ready, in_we;
  logic [2:0]  in_op;
  logic [31:0] in_addr, in_wdata;
  logic        out_valid, out_ready;
  logic [31:0] out_rdata;
  logic [1:0]  out_err;
  logic        mem_req, mem_gnt, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  always #5 clk = ~clk;

  lsu_mem_ctrl #(.TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_we(in_we), .in_op(in_op),
    .in_addr(in_addr), .in_wdata(in_wdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_rdata(out_rdata), .out_err(out_err),
    .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  // Expected outcome of one access. lat is the cycle (counted from 1 after the
  // accepting edge) in which out_valid first shows; req_cycles is how many
  // cycles mem_req is high, starting at cycle 1.
  typedef struct {
    logic [1:0]  err;
    logic [31:0] rdata;
    logic [31:0] maddr;
    logic [31:0] mwdata;
    logic [3:0]  mwmask;
    logic        mwe;
    int          req_cycles;
    int          lat;
  } exp_t;

  int          tests = 0;
  int          fails = 0;
  exp_t        cur;
  bit          busy = 0;
  bit          checking = 0;
  int          k = 0;
  bit          cur_we;
  int          cur_g, cur_r, cur_od;
  logic [31:0] cur_rword;
  logic [31:0] last_rdata, last_mwdata, last_maddr;
  logic [1:0]  last_err;
  logic [3:0]  last_mwmask;
  logic        last_mwe;
  int          last_lat;
  bit          req_seen;
  int          hs_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t, cycle %0d)", name, act, exp, $time, k);
    end
  endtask

  // Outcome from the access rules: size-based alignment, lane replication,
  // byte-range masks, extraction by shift-and-mask, and a cycle budget.
  function automatic exp_t model(input logic we, input logic [2:0] op, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [31:0] rword,
                                 input int g, input int r);
    exp_t        e;
    int          size, off, need;
    logic [31:0] word, keep;
    e.err = 2'b00; e.rdata = '0; e.mwdata = '0; e.mwmask = '0; e.mwe = 1'b0;
    e.req_cycles = 0; e.lat = 1;
    e.maddr = addr & 32'hFFFF_FFFC;
    off  = int'(addr[1:0]);
    size = (op[1:0] == 2'b00) ? 1 : (op[1:0] == 2'b01) ? 2 : 4;
    if (op == 3'b011 || op == 3'b110 || op == 3'b111) begin
      e.err = 2'b10;
      return e;
    end
    if (off % size != 0) begin
      e.err = 2'b01;
      return e;
    end
    e.mwe = we;
    if (we) begin
      for (int l = 0; l < 4; l++) begin
        e.mwdata[8*l +: 8] = wdata[8*(l % size) +: 8];
        e.mwmask[l] = (l >= off) && (l < off + size);
      end
    end
    need = (g + 1) + (we ? 0 : r + 1);
    if (need >= TMO) begin
      e.err = 2'b11;
      e.req_cycles = (g + 1 < TMO) ? g + 1 : TMO;
      e.lat = TMO + 1;
      return e;
    end
    e.req_cycles = g + 1;
    e.lat = need + 1;
    if (!we) begin
      word = rword >> (8 * off);
      keep = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * size)) - 32'd1);
      e.rdata = word & keep;
      if (!op[2] && size < 4 && word[8*size-1]) e.rdata = e.rdata | ~keep;
    end
    return e;
  endfunction

  // Per-cycle comparison of every observable output against the model.
  always @(negedge clk) begin
    if (checking) begin
      if (!busy) begin
        check("idle in_ready", 32'(in_ready), 32'd1);
        check("idle out_valid", 32'(out_valid), 32'd0);
        check("idle mem_req", 32'(mem_req), 32'd0);
      end else begin
        check("busy in_ready", 32'(in_ready), 32'd0);
        check("mem_req", 32'(mem_req), 32'(k <= cur.req_cycles));
        check("out_valid", 32'(out_valid), 32'(k >= cur.lat));
        if (mem_req) begin
          req_seen    = 1;
          last_maddr  = mem_addr;
          last_mwe    = mem_we;
          last_mwdata = mem_wdata;
          last_mwmask = mem_wmask;
          check("mem_addr", mem_addr, cur.maddr);
          check("mem_we", 32'(mem_we), 32'(cur.mwe));
          check("mem_wmask", 32'(mem_wmask), 32'(cur.mwmask));
          if (cur.mwe) check("mem_wdata", mem_wdata, cur.mwdata);
        end
        if (out_valid) begin
          last_rdata = out_rdata;
          last_err   = out_err;
          if (last_lat == 0) last_lat = k;
          if (out_ready) hs_cnt++;
          check("out_rdata", out_rdata, cur.rdata);
          check("out_err", 32'(out_err), 32'(cur.err));
        end
      end
    end
  end

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic idle_inputs();
    in_valid = 0; mem_gnt = 0; mem_rvalid = 0; out_ready = 0;
  endtask

  // Drive memory side, response ready and request noise for cycle k.
  task automatic drive_cycle();
    int d;
    d = cur_g + 2 + cur_r;
    mem_rdata = $urandom;
    if (cur.req_cycles == 0) begin
      mem_gnt    = rbit();
      mem_rvalid = rbit();
    end else begin
      mem_gnt = (k == cur_g + 1) ? 1'b1 : (k > cur_g + 1) ? rbit() : 1'b0;
      if (!cur_we) begin
        mem_rvalid = (k == d) ? 1'b1 : (k > cur_g + 1 && k < d) ? 1'b0 : rbit();
        if (k == d) mem_rdata = cur_rword;
      end else begin
        mem_rvalid = rbit();
      end
    end
    out_ready = (k < cur.lat) ? rbit() : 1'(k >= cur.lat + cur_od);
    in_valid  = rbit();
    in_we     = rbit();
    in_op     = 3'($urandom_range(0, 7));
    in_addr   = $urandom;
    in_wdata  = $urandom;
  endtask

  // One access: g extra REQ cycles before grant, r extra WAIT cycles before
  // read data, od cycles of out_ready held low, optional reset at cycle abort_k.
  task automatic do_txn(input logic we, input logic [2:0] op, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] rword,
                        input int g, input int r, input int od, input int abort_k);
    cur = model(we, op, addr, wdata, rword, g, r);
    cur_we = we; cur_g = g; cur_r = r; cur_od = od; cur_rword = rword;
    last_lat = 0; req_seen = 0; hs_cnt = 0;
    last_rdata = 32'hDEAD_BEEF; last_err = 2'bxx; last_mwdata = 32'hDEAD_BEEF;
    last_maddr = 32'hDEAD_BEEF; last_mwmask = 4'bxxxx; last_mwe = 1'bx;
    in_valid = 1; in_we = we; in_op = op; in_addr = addr; in_wdata = wdata;
    mem_gnt = 0; mem_rvalid = 0; out_ready = 0;
    @(posedge clk); #1;
    busy = 1; k = 1;
    drive_cycle();
    for (int n = 0; n < 100; n++) begin
      if (abort_k == k) begin
        #1 rst_n = 0;
        #1;
        check("reset mem_req", 32'(mem_req), 32'd0);
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset in_ready", 32'(in_ready), 32'd1);
        #1 rst_n = 1;
        busy = 0;
        idle_inputs();
        return;
      end
      @(posedge clk); #1;
      if (k == cur.lat + od) begin
        busy = 0;
        idle_inputs();
        return;
      end
      k++;
      drive_cycle();
    end
  endtask

  task automatic gap(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      mem_gnt = rbit(); mem_rvalid = rbit(); out_ready = rbit();
    end
  endtask

  initial begin
    logic [2:0] legal_ops [5];
    logic [2:0] op;
    int g, r;
    legal_ops = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    in_valid = 0; in_we = 0; in_op = 0; in_addr = 0; in_wdata = 0;
    out_ready = 0; mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;

    repeat (2) @(posedge clk);
    #1;
    check("rst in_ready", 32'(in_ready), 32'd1);
    check("rst out_valid", 32'(out_valid), 32'd0);
    check("rst out_rdata", out_rdata, 32'd0);
    check("rst out_err", 32'(out_err), 32'd0);
    check("rst mem_req", 32'(mem_req), 32'd0);
    check("rst mem_we", 32'(mem_we), 32'd0);
    check("rst mem_addr", mem_addr, 32'd0);
    check("rst mem_wdata", mem_wdata, 32'd0);
    check("rst mem_wmask", 32'(mem_wmask), 32'd0);
    rst_n = 1;
    checking = 1;

    // lb from the top lane, sign bit set.
    do_txn(1'b0, 3'b000, 32'h8000_0003, 32'h0, 32'h80FF_0000, 0, 0, 0, 0);
    check("lb rdata", last_rdata, 32'hFFFF_FF80);
    check("lb err", 32'(last_err), 32'd0);
    check("lb latency", 32'(last_lat), 32'd3);
    // lhu from the upper half.
    do_txn(1'b0, 3'b101, 32'h8000_0002, 32'h0, 32'hBEEF_1234, 0, 0, 1, 0);
    check("lhu rdata", last_rdata, 32'h0000_BEEF);
    // sb into lane 1.
    do_txn(1'b1, 3'b000, 32'h8000_0001, 32'h0000_00AB, 32'h0, 0, 0, 0, 0);
    check("sb wdata", last_mwdata, 32'hABAB_ABAB);
    check("sb wmask", 32'(last_mwmask), 32'h2);
    check("sb we", 32'(last_mwe), 32'd1);
    check("sb addr", last_maddr, 32'h8000_0000);
    check("sb latency", 32'(last_lat), 32'd2);
    // Misaligned word and illegal ops, including illegal-over-misaligned.
    do_txn(1'b0, 3'b010, 32'h8000_0002, 32'h0, 32'h0, 0, 0, 0, 0);
    check("lw misaligned err", 32'(last_err), 32'd1);
    check("lw misaligned latency", 32'(last_lat), 32'd1);
    check("lw misaligned req", 32'(req_seen), 32'd0);
    do_txn(1'b0, 3'b011, 32'h8000_0000, 32'h0, 32'h0, 0, 0, 0, 0);
    check("op011 err", 32'(last_err), 32'd2);
    do_txn(1'b1, 3'b111, 32'h8000_0003, 32'h0, 32'h0, 0, 0, 0, 0);
    check("illegal priority err", 32'(last_err), 32'd2);
    // Grant withheld 4 cycles, response back-pressured 3 cycles.
    do_txn(1'b0, 3'b010, 32'h8000_0004, 32'h0, 32'h1234_5678, 4, 0, 3, 0);
    check("stall rdata", last_rdata, 32'h1234_5678);
    check("stall latency", 32'(last_lat), 32'd7);
    check("stall handshakes", 32'(hs_cnt), 32'd1);
    // Timeouts: load with no read data, store with no grant.
    do_txn(1'b0, 3'b010, 32'h8000_0008, 32'h0, 32'h0, 0, 1000, 0, 0);
    check("load timeout err", 32'(last_err), 32'd3);
    check("load timeout latency", 32'(last_lat), 32'd9);
    check("load timeout rdata", last_rdata, 32'd0);
    do_txn(1'b1, 3'b010, 32'h8000_000C, 32'h5555_AAAA, 32'h0, 20, 0, 0, 0);
    check("store timeout err", 32'(last_err), 32'd3);
    // Reset pulsed while waiting for read data.
    do_txn(1'b0, 3'b010, 32'h8000_0010, 32'h0, 32'h0, 0, 50, 0, 3);
    gap(1);

    for (int i = 0; i < 300; i++) begin
      op = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7)) : legal_ops[$urandom_range(0, 4)];
      g  = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 9) : $urandom_range(0, 2);
      r  = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 8) : $urandom_range(0, 2);
      do_txn(rbit(), op, $urandom, $urandom, $urandom, g, r, $urandom_range(0, 2), 0);
      gap($urandom_range(0, 2));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
